msrv32_target_adder_pipe: RTL and testbench
===========================================

# msrv32_target_adder_pipe

Parametrised, pipelined target-address adder for the msrv32 core: computes `(iadder_src_in ? rs_1_in : pc_in) + imm_in` over a valid/ready stream. It optionally clears bit 0 for JALR and flags instruction-address misalignment. It sits between decode and the PC-mux/LSU in the multi-stage pipeline and replaces the single-cycle combinational immediate adder where timing requires a split carry chain.

## Interface

Parameters:

- `XLEN`, 32: operand and result width; must be even, ≥ 8.
- `STAGES`, 2: pipeline depth, 1 or 2. With 2, the carry chain is split at `XLEN/2`.
- `IALIGN_MASK`, 2'b10: result bits checked for misalignment. 2'b10 is IALIGN=32; 2'b00 disables the check (C extension).

Ports:

- `ms_riscv32_mp_clk_in`  in  1  clock. All state changes on the rising edge.
- `ms_riscv32_mp_rst_in`  in  1  asynchronous active-high reset.
- `valid_in`  in  1  input operands valid.
- `ready_out`  out  1  block can accept input this cycle.
- `iadder_src_in`  in  1  operand select: 0 = `pc_in`, 1 = `rs_1_in`.
- `jalr_in`  in  1  clear result bit 0 (JALR semantics).
- `pc_in`  in  XLEN  program counter.
- `rs_1_in`  in  XLEN  register source 1.
- `imm_in`  in  XLEN  sign-extended immediate.
- `flush_in`  in  1  synchronous kill of all in-flight entries.
- `valid_out`  out  1  result valid.
- `ready_in`  in  1  downstream accepts the result.
- `iadder_out`  out  XLEN  target address.
- `misaligned_out`  out  1  `|(iadder_out[1:0] & IALIGN_MASK)`; qualified by `valid_out`.

## Operation

- The input transfer happens when `valid_in && ready_out`. The output transfer happens when `valid_out && ready_in`.
- Each stage k has a valid bit `v[k]` and a data register. A stage loads when `!v[k] || adv[k+1]`, where the last stage advances on `ready_in`.
  - `ready_out` is therefore `!v[0] || adv[1]` and is combinational from `ready_in`.
  - There is no bubble: full throughput of one result per cycle while `ready_in` is held high.
- Arithmetic is modulo 2^XLEN. Overflow wraps silently and no carry-out is exported.
- `STAGES=1`:
  - Stage 0 registers the full sum.
  - `jalr_in` is applied before registering: bit 0 is forced to 0.
- `STAGES=2`:
  - Stage 0 registers the low-half sum, the carry out of bit `XLEN/2-1`, both high operand halves, and `jalr_in`.
  - Stage 1 registers the high half sum plus the registered carry, and applies the JALR bit-0 clear.
- `misaligned_out` is computed from the final (post-JALR) result. It is informational only; the transfer still completes.
- `flush_in` clears every `v[k]` at the next edge. An input presented in the same cycle as `flush_in` is dropped, even if `ready_out` was high. Data registers are not cleared.
- While `valid_out && !ready_in`, `iadder_out` and `misaligned_out` hold stable.

## Timing

- Reset (asynchronous, any time including mid-transfer):
  - all `v[k]`=0, all data registers 0;
  - `valid_out`=0, `iadder_out`=0, `misaligned_out`=0;
  - `ready_out`=1.
- Latency: an input accepted at edge N produces `valid_out`=1 after edge N+`STAGES-1`. It is first visible in the cycle following the accepting edge for `STAGES=1`, and one cycle later for `STAGES=2`.
- Occupancy is at most `STAGES`. When full and `ready_in`=0, `ready_out`=0.
- Simultaneous output transfer and input transfer in a full pipe is legal; the pipe shifts by one.
- `flush_in` has priority over all advance and accept events in its cycle.

## Structure

- Shared package `msrv32_pkg` holds:
  - `XLEN` default;
  - the IALIGN mask constants `IALIGN32_MASK`=2'b10 and `IALIGN16_MASK`=2'b00;
  - the operand-select encoding `IADDER_SRC_PC`=0 and `IADDER_SRC_RS1`=1.
- One sub-module, `msrv32_pipe_stage_ctrl`, holds the per-stage valid bit and load-enable logic. It is instantiated `STAGES` times, chained on `adv`.
- The adder datapath stays inline, selected by `generate` on `STAGES`.

## Test plan

1. Reset held, then released, with `valid_in`=0 → `valid_out`=0, `iadder_out`=0, `ready_out`=1.
2. PC source, `ready_in`=1: `pc_in`=0xAABBCCDD, `imm_in`=0x123, src=0 → `iadder_out`=0xAABBCE00 exactly `STAGES` edges after acceptance, `misaligned_out`=0.
3. JALR case: src=1, `rs_1_in`=0x11223344, `imm_in`=0x123, `jalr_in`=1 → 0x11223466, `misaligned_out`=1.
   - Repeat with `jalr_in`=0 → 0x11223467.
4. Carry split and wrap with `STAGES=2`:
   - 0x0000FFFF+0x00000001 → 0x00010000;
   - 0xFFFFFFFF+0x00000001 → 0x00000000;
   - back-to-back every cycle → one result per cycle, in order.
5. Backpressure: issue 3 ops and hold `ready_in`=0 → `ready_out` drops after `STAGES` accepts and `iadder_out` stays stable. Release → all results drain in order, none lost or duplicated.
6. Flush: with a full pipe plus `valid_in`=1, pulse `flush_in` → `valid_out`=0 next cycle and the concurrent input is discarded.
   - Repeat by asserting `ms_riscv32_mp_rst_in` mid-transfer → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/msrv32_target_adder_pipe_pkg.sv
// Shared msrv32 constants: default width, instruction-alignment masks and
// the operand-select encoding of the target-address adder.
package msrv32_pkg;

    localparam int MSRV32_XLEN = 32;

    // Result bits that must be zero for a legal instruction address
    localparam logic [1:0] IALIGN32_MASK = 2'b10;
    localparam logic [1:0] IALIGN16_MASK = 2'b00;

    // Operand select for the adder's first input
    localparam logic IADDER_SRC_PC  = 1'b0;
    localparam logic IADDER_SRC_RS1 = 1'b1;

    // True when any alignment-checked bit of the address is set
    function automatic logic addr_misaligned(input logic [1:0] low_bits,
                                             input logic [1:0] mask);
        return |(low_bits & mask);
    endfunction

endpackage

// File: rtl/msrv32_target_adder_pipe_if.sv
// Valid/ready stream bundle of the pipelined target-address adder.
// The slave side is the adder; the master side is its surroundings
// (decode on the input half, PC-mux/LSU on the output half).
interface msrv32_target_adder_pipe_if
    import msrv32_pkg::*;
#(
    parameter int XLEN = MSRV32_XLEN
);
    logic            valid_in;
    logic            ready_out;
    logic            iadder_src_in;
    logic            jalr_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs_1_in;
    logic [XLEN-1:0] imm_in;
    logic            flush_in;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] iadder_out;
    logic            misaligned_out;

    modport master (
        output valid_in, iadder_src_in, jalr_in, pc_in, rs_1_in, imm_in,
               flush_in, ready_in,
        input  ready_out, valid_out, iadder_out, misaligned_out
    );

    modport slave (
        input  valid_in, iadder_src_in, jalr_in, pc_in, rs_1_in, imm_in,
               flush_in, ready_in,
        output ready_out, valid_out, iadder_out, misaligned_out
    );
endinterface

// File: rtl/msrv32_target_adder_pipe_stage_ctrl.sv
// Per-stage occupancy bit and load enable. A stage may load when it is
// empty or its downstream neighbour takes its current content this cycle.
module msrv32_pipe_stage_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic up_vld,
    input  logic dn_rdy,
    output logic vld,
    output logic ld
);
    logic can_load;

    assign can_load = !vld || dn_rdy;
    assign ld       = can_load && up_vld;

    // Occupancy: flush wins, otherwise follow the upstream offer on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld <= 1'b0;
        else if (flush)
            vld <= 1'b0;
        else if (can_load)
            vld <= up_vld;
    end
endmodule

// File: rtl/msrv32_target_adder_pipe.sv
// Pipelined target-address adder: (src ? rs_1 : pc) + imm over a
// valid/ready stream, with JALR bit-0 clear and misalignment flag.
// STAGES=2 splits the carry chain at XLEN/2.
module msrv32_target_adder_pipe
    import msrv32_pkg::*;
#(
    parameter int         XLEN        = MSRV32_XLEN,
    parameter int         STAGES      = 2,
    parameter logic [1:0] IALIGN_MASK = IALIGN32_MASK
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_in,
    msrv32_target_adder_pipe_if.slave     bus
);
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   can_load;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   result;

    // Stage k can load unless it and every stage after it are full
    // while the sink stalls; written flat to avoid a combinational chain.
    assign can_load[STAGES] = bus.ready_in;
    for (genvar k = 0; k < STAGES; k++) begin : g_ctrl
        assign can_load[k] = bus.ready_in || !(&vld[STAGES-1:k]);

        msrv32_pipe_stage_ctrl u_ctrl (
            .clk    (ms_riscv32_mp_clk_in),
            .rst    (ms_riscv32_mp_rst_in),
            .flush  (bus.flush_in),
            .up_vld ((k == 0) ? bus.valid_in : vld[(k == 0) ? 0 : k-1]),
            .dn_rdy (can_load[k+1]),
            .vld    (vld[k]),
            .ld     (ld[k])
        );
    end

    assign op_a = (bus.iadder_src_in == IADDER_SRC_RS1) ? bus.rs_1_in : bus.pc_in;

    if (STAGES == 1) begin : g_one
        logic [XLEN-1:0] full_sum;
        logic [XLEN-1:0] sum_p0;

        assign full_sum = op_a + bus.imm_in;

        // Stage 0: full sum with JALR bit-0 clear
        always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
            if (ms_riscv32_mp_rst_in)
                sum_p0 <= '0;
            else if (ld[0])
                sum_p0 <= {full_sum[XLEN-1:1], full_sum[0] & ~bus.jalr_in};
        end

        assign result = sum_p0;
    end else begin : g_two
        localparam int HALF = XLEN / 2;

        logic [HALF:0]   lo_sum;
        logic [HALF-1:0] hi_sum;
        logic [HALF-1:0] lo_p0;
        logic [HALF-1:0] a_hi_p0;
        logic [HALF-1:0] b_hi_p0;
        logic            cy_p0;
        logic            jalr_p0;
        logic [XLEN-1:0] sum_p1;

        assign lo_sum = {1'b0, op_a[HALF-1:0]} + {1'b0, bus.imm_in[HALF-1:0]};

        // Stage 0: low half sum, its carry-out and the untouched high halves
        always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
            if (ms_riscv32_mp_rst_in) begin
                lo_p0   <= '0;
                cy_p0   <= 1'b0;
                a_hi_p0 <= '0;
                b_hi_p0 <= '0;
                jalr_p0 <= 1'b0;
            end else if (ld[0]) begin
                lo_p0   <= lo_sum[HALF-1:0];
                cy_p0   <= lo_sum[HALF];
                a_hi_p0 <= op_a[XLEN-1:HALF];
                b_hi_p0 <= bus.imm_in[XLEN-1:HALF];
                jalr_p0 <= bus.jalr_in;
            end
        end

        assign hi_sum = a_hi_p0 + b_hi_p0 + {{(HALF-1){1'b0}}, cy_p0};

        // Stage 1: high half with carry-in, JALR clears bit 0
        always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
            if (ms_riscv32_mp_rst_in)
                sum_p1 <= '0;
            else if (ld[STAGES-1])
                sum_p1 <= {hi_sum, lo_p0[HALF-1:1], lo_p0[0] & ~jalr_p0};
        end

        assign result = sum_p1;
    end

    assign bus.ready_out      = can_load[0];
    assign bus.valid_out      = vld[STAGES-1];
    assign bus.iadder_out     = result;
    assign bus.misaligned_out = addr_misaligned(result[1:0], IALIGN_MASK);
endmodule

// File: tb/tb_msrv32_target_adder_pipe.sv
// Bench for msrv32_target_adder_pipe (STAGES=2, IALIGN=32): a queue-based
// transaction model checked every cycle, plus directed literal vectors.
module tb_msrv32_target_adder_pipe;
    import msrv32_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    msrv32_target_adder_pipe_if #(.XLEN(XLEN)) bus ();

    msrv32_target_adder_pipe #(
        .XLEN        (XLEN),
        .STAGES      (STAGES),
        .IALIGN_MASK (IALIGN32_MASK)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    int   oc0;
    logic exp_v;
    logic exp_acc;

    function automatic logic [31:0] ref_target(input logic src, input logic jalr,
                                               input logic [31:0] pc,
                                               input logic [31:0] rs1,
                                               input logic [31:0] imm);
        logic [31:0] s;
        s = (src ? rs1 : pc) + imm;
        if (jalr) s[0] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transaction model: an accepted op becomes visible STAGES-1 edges after
    // its accepting edge, results leave in order, flush empties everything.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk1("rst_valid_out", bus.valid_out, 1'b0);
        end else begin
            exp_v   = (q.size() > 0) && (q[0].t <= cyc);
            exp_acc = bus.valid_in && ((q.size() < STAGES) || bus.ready_in);
            chk1("valid_out", bus.valid_out, exp_v);
            chk1("ready_out", bus.ready_out, (q.size() < STAGES) || bus.ready_in);
            if (exp_v && bus.valid_out) begin
                chk("iadder_out", bus.iadder_out, q[0].addr);
                chk1("misaligned_out", bus.misaligned_out, |(q[0].addr[1:0] & IALIGN32_MASK));
            end
            if (exp_v && bus.ready_in) begin
                void'(q.pop_front());
                out_count++;
            end
            if (bus.flush_in)
                q.delete();
            else if (exp_acc)
                q.push_back('{addr: ref_target(bus.iadder_src_in, bus.jalr_in, bus.pc_in,
                                               bus.rs_1_in, bus.imm_in),
                              t: cyc + STAGES});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic src, input logic jalr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] imm);
        bus.valid_in      = 1'b1;
        bus.iadder_src_in = src;
        bus.jalr_in       = jalr;
        bus.pc_in         = pc;
        bus.rs_1_in       = rs1;
        bus.imm_in        = imm;
    endtask

    task automatic one_op(input string nm, input logic src, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] imm, input logic [31:0] exp,
                          input logic mis);
        drive(src, jalr, pc, rs1, imm);
        bus.ready_in = 1'b1;
        chk1({nm, "_rdy"}, bus.ready_out, 1'b1);
        step();
        bus.valid_in = 1'b0;
        chk1({nm, "_early"}, bus.valid_out, 1'b0);
        step();
        chk1({nm, "_vld"}, bus.valid_out, 1'b1);
        chk({nm, "_addr"}, bus.iadder_out, exp);
        chk1({nm, "_mis"}, bus.misaligned_out, mis);
        step();
        chk1({nm, "_done"}, bus.valid_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in      = 1'b0;
        bus.iadder_src_in = 1'b0;
        bus.jalr_in       = 1'b0;
        bus.pc_in         = '0;
        bus.rs_1_in       = '0;
        bus.imm_in        = '0;
        bus.flush_in      = 1'b0;
        bus.ready_in      = 1'b0;

        // Reset state, held and released
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_hold_vld", bus.valid_out, 1'b0);
        chk("rst_hold_addr", bus.iadder_out, 32'h0);
        chk1("rst_hold_rdy", bus.ready_out, 1'b1);
        rst = 1'b0;
        step();
        step();
        chk1("rst_rel_vld", bus.valid_out, 1'b0);
        chk("rst_rel_addr", bus.iadder_out, 32'h0);
        chk1("rst_rel_mis", bus.misaligned_out, 1'b0);
        chk1("rst_rel_rdy", bus.ready_out, 1'b1);

        // PC source, JALR on/off, carry split and wrap
        one_op("pc_src",   IADDER_SRC_PC,  1'b0, 32'hAABBCCDD, 32'h0, 32'h123, 32'hAABBCE00, 1'b0);
        one_op("jalr1",    IADDER_SRC_RS1, 1'b1, 32'h0, 32'h11223344, 32'h123, 32'h11223466, 1'b1);
        one_op("jalr0",    IADDER_SRC_RS1, 1'b0, 32'h0, 32'h11223344, 32'h123, 32'h11223467, 1'b1);
        one_op("carry",    IADDER_SRC_PC,  1'b0, 32'h0000FFFF, 32'h0, 32'h1, 32'h00010000, 1'b0);
        one_op("wrap",     IADDER_SRC_RS1, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b0);

        // Back-to-back stream at full rate
        bus.ready_in = 1'b1;
        oc0 = out_count;
        for (int i = 0; i < 8; i++) begin
            drive(i[0], (i == 3), 32'h0000FFF0 + 32'(i) * 32'h00010003,
                  32'hFFFFFFF8 + 32'(i), 32'(i) * 32'h11);
            chk1("b2b_rdy", bus.ready_out, 1'b1);
            step();
        end
        bus.valid_in = 1'b0;
        repeat (3) step();
        chk("b2b_count", 32'(out_count - oc0), 32'd8);

        // Backpressure: pipe fills after two accepts, head holds stable
        bus.ready_in = 1'b0;
        drive(IADDER_SRC_PC, 1'b0, 32'h1000, 32'h0, 32'h4);
        step();
        drive(IADDER_SRC_PC, 1'b0, 32'h2000, 32'h0, 32'h8);
        chk1("bp_rdy1", bus.ready_out, 1'b1);
        step();
        drive(IADDER_SRC_PC, 1'b0, 32'h3000, 32'h0, 32'hC);
        for (int i = 0; i < 3; i++) begin
            chk1("bp_full_rdy", bus.ready_out, 1'b0);
            chk1("bp_hold_vld", bus.valid_out, 1'b1);
            chk("bp_hold_addr", bus.iadder_out, 32'h1004);
            step();
        end
        oc0 = out_count;
        bus.ready_in = 1'b1;
        step();
        bus.valid_in = 1'b0;
        chk("bp_drain1", bus.iadder_out, 32'h2008);
        step();
        chk("bp_drain2", bus.iadder_out, 32'h300C);
        step();
        chk1("bp_empty", bus.valid_out, 1'b0);
        chk("bp_count", 32'(out_count - oc0), 32'd3);

        // Flush with a full pipe and a concurrent input
        bus.ready_in = 1'b0;
        drive(IADDER_SRC_PC, 1'b0, 32'h4000, 32'h0, 32'h10);
        step();
        drive(IADDER_SRC_PC, 1'b0, 32'h5000, 32'h0, 32'h20);
        step();
        drive(IADDER_SRC_PC, 1'b0, 32'h6000, 32'h0, 32'h30);
        bus.flush_in = 1'b1;
        bus.ready_in = 1'b1;
        chk1("fl_pre_vld", bus.valid_out, 1'b1);
        step();
        bus.flush_in = 1'b0;
        bus.valid_in = 1'b0;
        chk1("fl_vld0", bus.valid_out, 1'b0);
        chk1("fl_rdy", bus.ready_out, 1'b1);
        step();
        chk1("fl_vld1", bus.valid_out, 1'b0);
        step();
        chk1("fl_vld2", bus.valid_out, 1'b0);

        // Asynchronous reset mid-transfer
        bus.ready_in = 1'b0;
        drive(IADDER_SRC_PC, 1'b0, 32'h7000, 32'h0, 32'h42);
        step();
        bus.valid_in = 1'b0;
        step();
        chk1("ar_pre_vld", bus.valid_out, 1'b1);
        chk("ar_pre_addr", bus.iadder_out, 32'h7042);
        chk1("ar_pre_mis", bus.misaligned_out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("ar_vld", bus.valid_out, 1'b0);
        chk("ar_addr", bus.iadder_out, 32'h0);
        chk1("ar_mis", bus.misaligned_out, 1'b0);
        chk1("ar_rdy", bus.ready_out, 1'b1);
        step();
        rst = 1'b0;
        step();
        one_op("post_rst", IADDER_SRC_RS1, 1'b1, 32'h0, 32'h00000100, 32'hFFFFFF21, 32'h00000020, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
